uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requesting AXI-Stream channels (legal 2..16).
REQ-002 SHALL have parameter DATA_W, default 8, byte width per channel.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per grant before forced release (legal 1..255).
REQ-004 SHALL have one clock; reset is asynchronous and active-low; ports named i_clk and i_rst.
REQ-005 i_clk  input  1  single clock domain.
REQ-006 i_rst  input  1  asynchronous active-low reset.
REQ-007 s_axis_data  input  NUM_CH*DATA_W  channel k byte at bits [k*DATA_W +: DATA_W].
REQ-008 s_axis_valid  input  NUM_CH  per-channel valid.
REQ-009 s_axis_last  input  NUM_CH  per-channel end-of-packet marker.
REQ-010 s_axis_ready  output  NUM_CH  per-channel ready; at most one bit high per cycle.
REQ-011 m_axis_data  output  DATA_W  byte toward the shared UART transmitter.
REQ-012 m_axis_valid  output  1  byte valid toward the transmitter.
REQ-013 m_axis_ready  input  1  transmitter ready (baud_en and not busy).
REQ-014 grant_id  output  4  index of the currently granted channel.
REQ-015 busy  output  1  high while any channel holds the grant.

Function
REQ-016 SHALL implement states IDLE, HDR (macro only) and STREAM.
REQ-017 In IDLE, SHALL round-robin select the first channel with valid high, starting at (last_grant+1) mod NUM_CH.
REQ-018 Arbitration SHALL take one cycle: on a request in IDLE, grant_id and busy update at the next edge and the state advances.
REQ-019 In STREAM: m_axis_data/m_axis_valid SHALL combinationally mirror the granted channel, and s_axis_ready[grant] SHALL equal m_axis_ready; all other ready bits SHALL be 0.
REQ-020 A beat SHALL transfer only when m_axis_valid and m_axis_ready are both high; the beat counter SHALL increment per transfer.
REQ-021 STREAM SHALL exit to IDLE after a transfer with s_axis_last[grant]=1, or after the MAX_BURST-th transfer, whichever occurs first.
REQ-022 On exit, busy SHALL fall at the same edge, last_grant SHALL update to grant_id, and the beat counter SHALL clear.
REQ-023 Deasserting the granted channel's valid mid-packet SHALL NOT release the grant; the arbiter SHALL wait indefinitely.
REQ-024 Valid changes on non-granted channels during STREAM SHALL have no effect.
REQ-025 In IDLE, m_axis_valid and all s_axis_ready bits SHALL be 0.
REQ-026 After a release, a single channel still requesting SHALL be re-granted (no starvation of a sole requester).

Reset
REQ-027 Asserting i_rst low SHALL immediately force state IDLE, busy=0, grant_id=0, beat counter=0, and last_grant=NUM_CH-1, so that channel 0 wins first.
REQ-028 During reset, m_axis_valid and s_axis_ready SHALL be 0, and m_axis_data SHALL be 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet; no completion beat is produced.

Configuration
REQ-030 Macro UART_ARB_HDR_EN: when defined, each grant SHALL pass IDLE -> HDR -> STREAM.
REQ-031 In HDR, SHALL drive m_axis_valid=1 with m_axis_data = 8'hA0 | grant_id; all s_axis_ready bits SHALL be 0; the state SHALL advance to STREAM on handshake.
REQ-032 The header SHALL NOT count toward MAX_BURST.
REQ-033 When UART_ARB_HDR_EN is not defined, HDR SHALL NOT exist, and IDLE SHALL go directly to STREAM.

Verification
REQ-034 Reset then ch0 and ch2 request simultaneously with 1-byte packets (last=1), m_axis_ready=1 -> ch0 byte first, then ch2; grant_id sequence 0, 2.
REQ-035 All four channels request continuously, 2-byte packets -> grant order 0,1,2,3,0; no interleaving of bytes within a packet.
REQ-036 ch1 sends 20 bytes with last never asserted, MAX_BURST=16 -> release after 16 transfers; ch1 is re-granted only after other pending channels.
REQ-037 ch3 is granted, its valid is dropped for 5 cycles mid-packet while ch0 requests -> grant stays 3; ch0 is served after ch3's last.
REQ-038 m_axis_ready toggles every 10 cycles (baud pacing) -> exactly one beat per ready-high cycle; data is stable while valid=1 and ready=0.
REQ-039 With UART_ARB_HDR_EN, ch2 sends byte 0x55 with last=1 -> output 0xA2 then 0x55; i_rst is pulsed low mid-packet -> valid and ready go to 0 immediately.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the per-channel AXI-Stream byte sources, the shared UART
// transmitter and the uart_tx_arbiter. The slave modport is the arbiter's view;
// the master modport is the view of whatever drives the channels and the TX.
interface uart_tx_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) ();
    logic [NUM_CH*DATA_W-1:0] s_axis_data;
    logic [NUM_CH-1:0]        s_axis_valid;
    logic [NUM_CH-1:0]        s_axis_last;
    logic [NUM_CH-1:0]        s_axis_ready;
    logic [DATA_W-1:0]        m_axis_data;
    logic                     m_axis_valid;
    logic                     m_axis_ready;
    logic [3:0]               grant_id;
    logic                     busy;

    modport master (
        output s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
        input  s_axis_ready, m_axis_data, m_axis_valid, grant_id, busy
    );

    modport slave (
        input  s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
        output s_axis_ready, m_axis_data, m_axis_valid, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_CH AXI-Stream byte
// channels share one UART transmitter, one packet (or MAX_BURST beats) per grant.
// Optional macro UART_ARB_HDR_EN: prefix every grant with a header byte
// 8'hA0 | grant_id that does not count toward MAX_BURST.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no grant; pick next requester round-robin from last_grant+1
// ST_HDR    | (UART_ARB_HDR_EN only) emit header byte for the new grant
// ST_STREAM | granted channel is wired straight through to the transmitter
module uart_tx_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    uart_tx_arbiter_if.slave bus
);

`ifdef UART_ARB_HDR_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HDR = 2'd1, ST_STREAM = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd2} state_t;
`endif

    // Beat counter holds beats already sent in this grant, so the burst
    // limit is reached when the transfer happens at count MAX_BURST-1.
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);
    localparam logic [3:0] RST_LAST  = 4'(NUM_CH - 1);

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  last_grant_q, last_grant_d;
    logic        busy_q, busy_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;

    logic [NUM_CH-1:0] gnt_sel;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic              found_hi;
    logic [3:0]        pick_hi, pick_lo, pick;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [NUM_CH-1:0] s_ready;
    logic              xfer;

    // Select the granted channel's stream with a one-hot decode of grant_q
    always_comb begin
        gnt_sel = '0;
        g_data  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            gnt_sel[k] = (grant_q == 4'(k));
            if (grant_q == 4'(k)) begin
                g_data = bus.s_axis_data[k*DATA_W +: DATA_W];
            end
        end
        g_valid = |(bus.s_axis_valid & gnt_sel);
        g_last  = |(bus.s_axis_last & gnt_sel);
    end

    // Round-robin pick: lowest requester above last_grant, else lowest at/below it
    always_comb begin
        found_hi = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (bus.s_axis_valid[k]) begin
                if (4'(k) > last_grant_q) begin
                    found_hi = 1'b1;
                    pick_hi  = 4'(k);
                end else begin
                    pick_lo = 4'(k);
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    // Output steering: everything quiet in IDLE, pass-through in STREAM
    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        s_ready = '0;
        case (state_q)
`ifdef UART_ARB_HDR_EN
            ST_HDR: begin
                m_valid = 1'b1;
                m_data  = DATA_W'(8'hA0 | {4'h0, grant_q});
            end
`endif
            ST_STREAM: begin
                m_valid = g_valid;
                m_data  = g_data;
                s_ready = gnt_sel & {NUM_CH{bus.m_axis_ready}};
            end
            default: ;
        endcase
    end

    assign xfer             = m_valid & bus.m_axis_ready;
    assign bus.m_axis_valid = m_valid;
    assign bus.m_axis_data  = m_data;
    assign bus.s_axis_ready = s_ready;
    assign bus.grant_id     = grant_q;
    assign bus.busy         = busy_q;

    // Next-state logic for grant, burst counting and release
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.s_axis_valid) begin
                    grant_d    = pick;
                    busy_d     = 1'b1;
                    beat_cnt_d = '0;
`ifdef UART_ARB_HDR_EN
                    state_d    = ST_HDR;
`else
                    state_d    = ST_STREAM;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            ST_HDR: begin
                if (bus.m_axis_ready) begin
                    state_d = ST_STREAM;
                end
            end
`endif
            ST_STREAM: begin
                if (xfer) begin
                    if (g_last || beat_cnt_q == LAST_BEAT) begin
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset leaves last_grant at NUM_CH-1 so channel 0 wins first
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= RST_LAST;
            busy_q       <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: per-channel byte queues feed the DUT, a
// packet-level reference model predicts grant, busy and output every cycle.
module tb_uart_tx_arbiter;
    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 16;
`ifdef UART_ARB_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    uart_tx_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Source side: each channel replays a list of {last, byte} entries
    logic [8:0]        src_buf [NUM_CH][256];
    int                wr_ptr  [NUM_CH];
    int                rd_ptr  [NUM_CH];
    logic [NUM_CH-1:0] hold;
    logic [NUM_CH-1:0] fire;
    bit                gap_en;
    int                ready_mode;
    int                cyc;

    logic [7:0] oq[$];
    int         gq[$];
    logic       busy_prev;
    logic       prev_mv, prev_mr;
    logic [7:0] prev_md;

    // Reference model: owner channel (-1 = free), beats sent, header pending
    int m_own, m_grant, m_lastg, m_beats;
    bit m_hdr;

    task automatic push_byte(input int c, input logic [7:0] d, input logic l);
        src_buf[c][wr_ptr[c]] = {l, d};
        wr_ptr[c]++;
    endtask

    task automatic model_reset();
        m_own   = -1;
        m_grant = 0;
        m_lastg = NUM_CH - 1;
        m_beats = 0;
        m_hdr   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_update();
        if (m_own < 0) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                automatic int c = (m_lastg + i) % NUM_CH;
                if (m_own < 0 && bus.s_axis_valid[c]) begin
                    m_own   = c;
                    m_grant = c;
                    m_hdr   = HDR_EN;
                end
            end
        end else if (m_hdr) begin
            if (bus.m_axis_ready) m_hdr = 1'b0;
        end else if (bus.s_axis_valid[m_own] && bus.m_axis_ready) begin
            m_beats++;
            if (bus.s_axis_last[m_own] || m_beats == MAX_BURST) begin
                m_lastg = m_own;
                m_own   = -1;
                m_beats = 0;
            end
        end
    endtask

    task automatic drive();
        logic [NUM_CH-1:0]        v;
        logic [NUM_CH-1:0]        l;
        logic [NUM_CH*DATA_W-1:0] d;
        logic [8:0]               head;
        v = '0; l = '0; d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (fire[c]) rd_ptr[c]++;
            head = (rd_ptr[c] < wr_ptr[c]) ? src_buf[c][rd_ptr[c]] : 9'h000;
            v[c] = (rd_ptr[c] < wr_ptr[c]) && !hold[c] &&
                   (!gap_en || $urandom_range(0, 3) != 0);
            l[c] = head[8];
            d[c*DATA_W +: DATA_W] = head[7:0];
        end
        fire = '0;
        bus.s_axis_valid = v;
        bus.s_axis_last  = l;
        bus.s_axis_data  = d;
        case (ready_mode)
            0:       bus.m_axis_ready = 1'b1;
            1:       bus.m_axis_ready = ((cyc / 10) % 2) == 0;
            default: bus.m_axis_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic sample();
        logic              exp_mv;
        logic [7:0]        exp_md;
        logic [NUM_CH-1:0] exp_sr;
        exp_mv = 1'b0; exp_md = '0; exp_sr = '0;
        if (m_own >= 0) begin
            if (m_hdr) begin
                exp_mv = 1'b1;
                exp_md = 8'hA0 | 8'(m_own);
            end else begin
                exp_mv = bus.s_axis_valid[m_own];
                exp_md = bus.s_axis_data[m_own*DATA_W +: DATA_W];
                exp_sr[m_own] = bus.m_axis_ready;
            end
        end
        check("busy", bus.busy, m_own >= 0);
        check("grant_id", bus.grant_id, m_grant);
        check("m_valid", bus.m_axis_valid, exp_mv);
        check("m_data", bus.m_axis_data, exp_md);
        check("s_ready", bus.s_axis_ready, exp_sr);
        if (prev_mv && !prev_mr && bus.m_axis_valid)
            check("stall_stable", bus.m_axis_data, prev_md);
        prev_mv = bus.m_axis_valid;
        prev_mr = bus.m_axis_ready;
        prev_md = bus.m_axis_data;
        fire = bus.s_axis_valid & bus.s_axis_ready;
        if (bus.m_axis_valid && bus.m_axis_ready) oq.push_back(bus.m_axis_data);
        if (bus.busy && !busy_prev) gq.push_back(int'(bus.grant_id));
        busy_prev = bus.busy;
    endtask

    task automatic step();
        @(posedge i_clk);
        model_update();
        #1;
        cyc++;
        drive();
        @(negedge i_clk);
        sample();
    endtask

    function automatic bit drained();
        for (int c = 0; c < NUM_CH; c++)
            if (wr_ptr[c] - rd_ptr[c] - int'(fire[c]) > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!drained() && n < max_cyc) begin
            step();
            n++;
        end
        check({tag, "_drained"}, drained(), 1'b1);
        repeat (3) step();
    endtask

    task automatic flush_sources();
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] = 0;
            rd_ptr[c] = 0;
        end
        hold = '0; fire = '0;
        bus.s_axis_valid = '0;
        bus.s_axis_last  = '0;
        bus.s_axis_data  = '0;
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        flush_sources();
        gap_en = 1'b0; ready_mode = 0; cyc = 0;
        bus.m_axis_ready = 1'b0;
        oq.delete(); gq.delete();
        busy_prev = 1'b0; prev_mv = 1'b0; prev_mr = 1'b0; prev_md = '0;
        model_reset();
        repeat (2) @(negedge i_clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_grant", bus.grant_id, 4'd0);
        check("rst_m_valid", bus.m_axis_valid, 1'b0);
        check("rst_m_data", bus.m_axis_data, 8'h00);
        check("rst_s_ready", bus.s_axis_ready, 4'h0);
        i_rst = 1'b1;
    endtask

    task automatic check_grants(input string tag, input int e[$]);
        check({tag, "_ngrants"}, gq.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            check($sformatf("%s_grant%0d", tag, i), (i < gq.size()) ? gq[i] : -1, e[i]);
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] e[$]);
        check({tag, "_nbytes"}, oq.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), (i < oq.size()) ? 32'(oq[i]) : 32'hFFFF, 32'(e[i]));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         eg[$];
        logic [7:0] eb[$];

        // Simultaneous 1-byte packets on ch0 and ch2: ch0 wins after reset
        do_reset();
        push_byte(0, 8'h11, 1'b1);
        push_byte(2, 8'h22, 1'b1);
        run_drain("two_req", 50);
        eg.delete(); eg.push_back(0); eg.push_back(2);
        check_grants("two_req", eg);
        eb.delete();
        if (HDR_EN) eb.push_back(8'hA0);
        eb.push_back(8'h11);
        if (HDR_EN) eb.push_back(8'hA2);
        eb.push_back(8'h22);
        check_bytes("two_req", eb);

        // All channels, two 2-byte packets each: strict rotation, no interleave
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < NUM_CH; c++)
                for (int b = 0; b < 2; b++)
                    push_byte(c, 8'(c*16 + p*4 + b), b == 1);
        run_drain("all_ch", 200);
        eg.delete(); eb.delete();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < NUM_CH; c++) begin
                eg.push_back(c);
                if (HDR_EN) eb.push_back(8'hA0 | 8'(c));
                for (int b = 0; b < 2; b++) eb.push_back(8'(c*16 + p*4 + b));
            end
        check_grants("all_ch", eg);
        check_bytes("all_ch", eb);

        // ch1 never asserts last: forced release after MAX_BURST beats
        do_reset();
        for (int i = 0; i < 20; i++) push_byte(1, 8'(8'h40 + i), 1'b0);
        repeat (3) step();
        push_byte(0, 8'h01, 1'b1);
        push_byte(2, 8'h02, 1'b1);
        run_drain("burst", 300);
        eg.delete(); eg.push_back(1); eg.push_back(2); eg.push_back(0); eg.push_back(1);
        check_grants("burst", eg);

        // ch3 drops valid mid-packet while ch0 waits: grant must stay on ch3
        do_reset();
        for (int i = 0; i < 6; i++) push_byte(3, 8'(8'h30 + i), i == 5);
        repeat (4) step();
        hold[3] = 1'b1;
        push_byte(0, 8'h0A, 1'b1);
        repeat (5) step();
        hold[3] = 1'b0;
        run_drain("hold", 100);
        eg.delete(); eg.push_back(3); eg.push_back(0);
        check_grants("hold", eg);

        // Baud-paced transmitter ready: one beat per ready-high cycle, data held
        do_reset();
        ready_mode = 1;
        for (int i = 0; i < 15; i++) push_byte(0, 8'(8'hC0 + i), (i % 5) == 4);
        for (int i = 0; i < 5; i++)  push_byte(2, 8'(8'hE0 + i), i == 4);
        run_drain("paced", 1000);
        check("paced_nbytes", oq.size(), HDR_EN ? 24 : 20);

        // Randomized traffic, gaps on valid and random transmitter ready
        for (int r = 0; r < 4; r++) begin
            do_reset();
            gap_en = 1'b1;
            ready_mode = 2;
            for (int c = 0; c < NUM_CH; c++) begin
                automatic int npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    automatic int len = $urandom_range(1, 20);
                    for (int b = 0; b < len; b++)
                        push_byte(c, 8'($urandom_range(0, 255)), b == len - 1);
                end
            end
            run_drain("random", 3000);
        end

`ifdef UART_ARB_HDR_EN
        // Header byte precedes the payload
        do_reset();
        push_byte(2, 8'h55, 1'b1);
        run_drain("hdr", 50);
        eb.delete(); eb.push_back(8'hA2); eb.push_back(8'h55);
        check_bytes("hdr", eb);
`endif

        // Reset asserted mid-packet: outputs drop immediately, packet abandoned
        do_reset();
        for (int i = 0; i < 10; i++) push_byte(1, 8'(8'h70 + i), i == 9);
        repeat (5) step();
        check("midrst_busy_before", bus.busy, 1'b1);
        #2;
        i_rst = 1'b0;
        #1;
        check("midrst_m_valid", bus.m_axis_valid, 1'b0);
        check("midrst_s_ready", bus.s_axis_ready, 4'h0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_grant", bus.grant_id, 4'd0);
        check("midrst_m_data", bus.m_axis_data, 8'h00);
        flush_sources();
        model_reset();
        oq.delete();
        busy_prev = 1'b0; prev_mv = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (5) step();
        check("midrst_no_beats", oq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
